i2c_bus_recovery: RTL

Downstream consumer of the millisecond timeout timer. It watches the synchronised I2C SCL/SDA pins and treats a line held low as a stuck bus. It arms the timer for STUCK_MS milliseconds. If the condition persists to timeout, it clocks up to RECOVERY_PULSES SCL pulses, then issues a STOP to free a slave wedged mid-byte. It sits between the pin pads and the CPLD's I2C slave/master logic and reports recovery success or failure.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_sync2.sv | 39 +++
 rtl/i2c_bus_recovery.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C bus recovery block.
//   - state_e : recovery state machine encoding (3 bits)
//   - TMR_W   : width of the millisecond timer terminal count
//   - *_DEF   : default half-period, stuck time and pulse budget
package i2c_pkg;

    localparam int unsigned TMR_W               = 11;
    localparam int unsigned CLK_DIV_DEF         = 125;
    localparam int unsigned STUCK_MS_DEF        = 35;
    localparam int unsigned RECOVERY_PULSES_DEF = 9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_TO  = 3'd1,
        PULSE_LO = 3'd2,
        PULSE_HI = 3'd3,
        STOP_A   = 3'd4,
        STOP_B   = 3'd5,
        STOP_C   = 3'd6,
        CHECK    = 3'd7
    } state_e;

    // SCL is pulled low during the low half of each recovery pulse and
    // during the first phase of the STOP sequence.
    function automatic logic scl_drive(input state_e st);
        return (st == PULSE_LO) || (st == STOP_A);
    endfunction

    // The supervisor is busy whenever it is actively recovering.
    function automatic logic is_busy(input state_e st);
        return (st != IDLE) && (st != WAIT_TO);
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// i2c_sync2: two-flop synchroniser for an asynchronous pin level.
//   sys_clk   : clock
//   sys_rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d         : asynchronous input
//   q         : synchronised output (2-cycle latency)
module i2c_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next values of the synchroniser chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops; reset to the idle-bus level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_bus_recovery.sv
// i2c_bus_recovery: detects an I2C bus held low, waits STUCK_MS via an
// external millisecond timer, then clocks up to RECOVERY_PULSES SCL pulses
// and (optionally) a STOP condition to free a wedged slave.
//
// Build option: define I2C_RECOVERY_STOP_EN to generate the STOP_A/B/C
// sequence; without it PULSE_HI exits straight to CHECK and sda_oe stays 0.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   scl_in, sda_in     : raw pin levels (asynchronous)
//   recover_req        : single-cycle forced recovery request (IDLE only)
//   tmr_timeout        : timeout from the millisecond timer
//   tmr_en             : timer count enable (high only in WAIT_TO)
//   tmr_size           : timer terminal count (constant STUCK_MS)
//   scl_oe, sda_oe     : 1 = drive the line low
//   busy               : high while recovering
//   recovered, fail    : one-cycle result pulses
module i2c_bus_recovery
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV         = CLK_DIV_DEF,
    parameter int unsigned STUCK_MS        = STUCK_MS_DEF,
    parameter int unsigned RECOVERY_PULSES = RECOVERY_PULSES_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             recover_req,
    input  logic             tmr_timeout,
    output logic             tmr_en,
    output logic [TMR_W-1:0] tmr_size,
    output logic             scl_oe,
    output logic             sda_oe,
    output logic             busy,
    output logic             recovered,
    output logic             fail
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] PULSE_MAX = 4'(RECOVERY_PULSES);

    logic       scl_s;
    logic       sda_s;
    logic       stuck_s;
    logic       div_last_s;
    logic [3:0] pcnt_inc_s;

    state_e     state_d,     state_q;
    logic [7:0] div_d,       div_q;
    logic [3:0] pcnt_d,      pcnt_q;
    logic       tmr_en_d,    tmr_en_q;
    logic       scl_oe_d,    scl_oe_q;
    logic       sda_oe_d,    sda_oe_q;
    logic       busy_d,      busy_q;
    logic       recovered_d, recovered_q;
    logic       fail_d,      fail_q;

    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_scl (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (scl_in),
        .q         (scl_s)
    );

    i2c_sync2 #(.RST_VAL(1'b1)) u_sync_sda (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (sda_in),
        .q         (sda_s)
    );

    assign stuck_s    = !scl_s || !sda_s;
    assign div_last_s = (div_q == DIV_LAST);
    assign pcnt_inc_s = pcnt_q + 4'd1;

    // Next-state logic; outputs are decoded from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        pcnt_d      = pcnt_q;
        recovered_d = 1'b0;
        fail_d      = 1'b0;

        case (state_q)
            IDLE: begin
                div_d  = 8'd0;
                pcnt_d = 4'd0;
                if (recover_req) begin
                    state_d = PULSE_LO;
                end else if (stuck_s) begin
                    state_d = WAIT_TO;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_TO: begin
                div_d = 8'd0;
                if (!stuck_s) begin
                    state_d = IDLE;
                end else if (tmr_timeout) begin
                    pcnt_d  = 4'd0;
                    state_d = PULSE_LO;
                end else begin
                    state_d = WAIT_TO;
                end
            end
            PULSE_LO: begin
                if (div_last_s) begin
                    div_d   = 8'd0;
                    state_d = PULSE_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            PULSE_HI: begin
                if (div_last_s) begin
                    div_d  = 8'd0;
                    pcnt_d = pcnt_inc_s;
                    // Stop early once the slave has let go of SDA.
                    if (sda_s || (pcnt_inc_s == PULSE_MAX)) begin
`ifdef I2C_RECOVERY_STOP_EN
                        state_d = STOP_A;
`else
                        state_d = CHECK;
`endif
                    end else begin
                        state_d = PULSE_LO;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
`ifdef I2C_RECOVERY_STOP_EN
            STOP_A: begin
                if (div_last_s) begin
                    div_d   = 8'd0;
                    state_d = STOP_B;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            STOP_B: begin
                if (div_last_s) begin
                    div_d   = 8'd0;
                    state_d = STOP_C;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            STOP_C: begin
                if (div_last_s) begin
                    div_d   = 8'd0;
                    state_d = CHECK;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
`endif
            CHECK: begin
                div_d   = 8'd0;
                state_d = IDLE;
                if (scl_s && sda_s) begin
                    recovered_d = 1'b1;
                end else begin
                    fail_d = 1'b1;
                end
            end
            default: begin
                div_d   = 8'd0;
                state_d = IDLE;
            end
        endcase

        tmr_en_d = (state_d == WAIT_TO);
        scl_oe_d = scl_drive(state_d);
`ifdef I2C_RECOVERY_STOP_EN
        sda_oe_d = (state_d == STOP_A) || (state_d == STOP_B);
`else
        sda_oe_d = 1'b0;
`endif
        busy_d   = is_busy(state_d);
    end

    // State, half-period counter and pulse counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            pcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Registered outputs; reset releases both lines immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmr_en_q    <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            recovered_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            tmr_en_q    <= tmr_en_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            recovered_q <= recovered_d;
            fail_q      <= fail_d;
        end
    end

    assign tmr_en    = tmr_en_q;
    assign tmr_size  = TMR_W'(STUCK_MS);
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign recovered = recovered_q;
    assign fail      = fail_q;

endmodule
